// File: rtl/trap_ctrl_if.sv
// rtl/trap_ctrl_if.sv - pipeline/CSR-file bundle seen by the machine-mode trap sequencer
// Signals:
//   inst_valid_i, inst_pc_i, ecall_i, ebreak_i, mret_i : EX-stage instruction and its trap requests
//   ex_csr_we_i                                        : EX owns the CSR write port this cycle
//   mstatus_i, mepc_i, mtvec_i, mie_i, mip_i           : live CSR values (combinational reads)
//   ctrl_waddr_o, ctrl_wdata_o, ctrl_we_o              : sequencer CSR write port
//   hold_o, jump_o, jump_addr_o                        : pipeline stall and redirect
// Modports: master = pipeline/CSR side, slave = trap_ctrl.
interface trap_ctrl_if;
    logic        inst_valid_i;
    logic [31:0] inst_pc_i;
    logic        ecall_i;
    logic        ebreak_i;
    logic        mret_i;
    logic        ex_csr_we_i;
    logic [31:0] mstatus_i;
    logic [31:0] mepc_i;
    logic [31:0] mtvec_i;
    logic [31:0] mie_i;
    logic [31:0] mip_i;
    logic [11:0] ctrl_waddr_o;
    logic [31:0] ctrl_wdata_o;
    logic        ctrl_we_o;
    logic        hold_o;
    logic        jump_o;
    logic [31:0] jump_addr_o;

    modport master (
        output inst_valid_i, inst_pc_i, ecall_i, ebreak_i, mret_i, ex_csr_we_i,
        output mstatus_i, mepc_i, mtvec_i, mie_i, mip_i,
        input  ctrl_waddr_o, ctrl_wdata_o, ctrl_we_o, hold_o, jump_o, jump_addr_o
    );

    modport slave (
        input  inst_valid_i, inst_pc_i, ecall_i, ebreak_i, mret_i, ex_csr_we_i,
        input  mstatus_i, mepc_i, mtvec_i, mie_i, mip_i,
        output ctrl_waddr_o, ctrl_wdata_o, ctrl_we_o, hold_o, jump_o, jump_addr_o
    );
endinterface

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap sequencer: accepts traps/mret, writes mepc/mcause/mstatus, redirects
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : trap_ctrl_if.slave (EX requests, live CSR values, CSR write port, hold/jump)
// Parameter:
//   VECTORED_EN : when 1, interrupts honour mtvec mode 1 (base + 4*cause); when 0 all traps use base.
module trap_ctrl #(
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    trap_ctrl_if.slave  bus
);
    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;
    localparam logic [31:0] CAUSE_ECALL  = 32'h0000_000B;
    localparam logic [31:0] CAUSE_EBREAK = 32'h0000_0003;

    typedef enum logic [2:0] {
        IDLE, WR_MEPC, WR_MCAUSE, WR_MSTATUS, MRET_WR, JUMP
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] saved_pc_q, saved_pc_d;
    logic [31:0] saved_cause_q, saved_cause_d;
    logic        mret_q, mret_d;

    logic        irq;
    logic [31:0] base;
    logic [31:0] mstatus_trap;
    logic [31:0] mstatus_mret;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        we;
    logic        hold;
    logic        jump;
    logic [31:0] jaddr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            saved_pc_q    <= '0;
            saved_cause_q <= '0;
            mret_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            saved_pc_q    <= saved_pc_d;
            saved_cause_q <= saved_cause_d;
            mret_q        <= mret_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        saved_pc_d    = saved_pc_q;
        saved_cause_d = saved_cause_q;
        mret_d        = mret_q;
        waddr         = '0;
        wdata         = '0;
        we            = 1'b0;
        hold          = 1'b0;
        jump          = 1'b0;
        jaddr         = '0;

        irq  = bus.mstatus_i[3] & bus.mie_i[7] & bus.mip_i[7];
        base = {bus.mtvec_i[31:2], 2'b00};

        mstatus_trap        = bus.mstatus_i;
        mstatus_trap[7]     = bus.mstatus_i[3];
        mstatus_trap[3]     = 1'b0;
        mstatus_trap[12:11] = 2'b11;

        mstatus_mret        = bus.mstatus_i;
        mstatus_mret[3]     = bus.mstatus_i[7];
        mstatus_mret[7]     = 1'b1;
        mstatus_mret[12:11] = 2'b11;

        unique case (state_q)
            IDLE: begin
                // Acceptance drives hold_o combinationally, so it is gated while reset
                // is asserted to keep every output at zero during reset.
                if (rst_ni && bus.inst_valid_i) begin
                    if (irq) begin
                        saved_cause_d = CAUSE_TIMER;
                        state_d       = WR_MEPC;
                    end else if (bus.ecall_i) begin
                        saved_cause_d = CAUSE_ECALL;
                        state_d       = WR_MEPC;
                    end else if (bus.ebreak_i) begin
                        saved_cause_d = CAUSE_EBREAK;
                        state_d       = WR_MEPC;
                    end else if (bus.mret_i) begin
                        state_d       = MRET_WR;
                    end
                    if (state_d != IDLE) begin
                        hold       = 1'b1;
                        saved_pc_d = bus.inst_pc_i;
                        mret_d     = (state_d == MRET_WR);
                    end
                end
            end
            // Each write state yields the port to EX and retries the same write next cycle.
            WR_MEPC: begin
                hold  = 1'b1;
                waddr = ADDR_MEPC;
                wdata = saved_pc_q;
                if (!bus.ex_csr_we_i) begin
                    we      = 1'b1;
                    state_d = WR_MCAUSE;
                end
            end
            WR_MCAUSE: begin
                hold  = 1'b1;
                waddr = ADDR_MCAUSE;
                wdata = saved_cause_q;
                if (!bus.ex_csr_we_i) begin
                    we      = 1'b1;
                    state_d = WR_MSTATUS;
                end
            end
            WR_MSTATUS: begin
                hold  = 1'b1;
                waddr = ADDR_MSTATUS;
                wdata = mstatus_trap;
                if (!bus.ex_csr_we_i) begin
                    we      = 1'b1;
                    state_d = JUMP;
                end
            end
            MRET_WR: begin
                hold  = 1'b1;
                waddr = ADDR_MSTATUS;
                wdata = mstatus_mret;
                if (!bus.ex_csr_we_i) begin
                    we      = 1'b1;
                    state_d = JUMP;
                end
            end
            JUMP: begin
                // mepc_i/mtvec_i are read here, after all writes landed.
                hold    = 1'b1;
                jump    = 1'b1;
                state_d = IDLE;
                if (mret_q) begin
                    jaddr = bus.mepc_i;
                end else if (VECTORED_EN && bus.mtvec_i[1:0] == 2'b01 && saved_cause_q[31]) begin
                    jaddr = base + {saved_cause_q[29:0], 2'b00};
                end else begin
                    jaddr = base;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ctrl_waddr_o = waddr;
    assign bus.ctrl_wdata_o = wdata;
    assign bus.ctrl_we_o    = we;
    assign bus.hold_o       = hold;
    assign bus.jump_o       = jump;
    assign bus.jump_addr_o  = jaddr;

    logic unused_bits;
    assign unused_bits = ^{bus.mie_i[31:8], bus.mie_i[6:0], bus.mip_i[31:8], bus.mip_i[6:0],
                           saved_cause_q[30]};
endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - randomized self-checking bench for trap_ctrl against a write-list reference model
module tb_trap_ctrl;
    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    trap_ctrl_if bus();

    trap_ctrl #(.VECTORED_EN(1'b1)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic        c_ecall, c_ebreak, c_mret;
    logic [31:0] c_pc, c_ms, c_mepc, c_mtvec, c_mie, c_mip;
    logic        coll [32];

    logic        exp_hold  [32];
    logic        exp_we    [32];
    logic        exp_jump  [32];
    logic        exp_chk   [32];
    logic [11:0] exp_waddr [32];
    logic [31:0] exp_wdata [32];
    logic [31:0] exp_jaddr [32];
    int          exp_len;

    task automatic put(input int k, input logic h, input logic w, input logic j, input logic ch,
                       input logic [11:0] a, input logic [31:0] d, input logic [31:0] ja);
        exp_hold[k] = h; exp_we[k] = w; exp_jump[k] = j; exp_chk[k] = ch;
        exp_waddr[k] = a; exp_wdata[k] = d; exp_jaddr[k] = ja;
    endtask

    // Reference: decide the request by priority, list the CSR writes it implies, then lay them
    // out over cycles, skipping cycles where EX owns the port, followed by the redirect.
    task automatic model();
        logic [11:0] qa [$];
        logic [31:0] qd [$];
        logic        irq;
        int          kind;
        int          k;
        logic [31:0] cause, base, tgt, ms_trap, ms_mret;
        irq   = c_ms[3] && c_mie[7] && c_mip[7];
        kind  = 0;
        cause = 0;
        if (irq)           begin kind = 1; cause = 32'h8000_0007; end
        else if (c_ecall)  begin kind = 1; cause = 32'd11; end
        else if (c_ebreak) begin kind = 1; cause = 32'd3; end
        else if (c_mret)   kind = 2;
        base    = c_mtvec & ~32'h3;
        ms_trap = (c_ms & ~32'h88) | (c_ms[3] ? 32'h80 : 32'h0) | 32'h1800;
        ms_mret = (c_ms & ~32'h8) | (c_ms[7] ? 32'h8 : 32'h0) | 32'h80 | 32'h1800;
        tgt     = c_mepc;
        if (kind == 1) begin
            qa = '{12'h341, 12'h342, 12'h300};
            qd = '{c_pc, cause, ms_trap};
            tgt = (irq && c_mtvec[1:0] == 2'b01) ? base + 4 * (cause & 32'h7fff_ffff) : base;
        end else if (kind == 2) begin
            qa = '{12'h300};
            qd = '{ms_mret};
        end
        put(0, kind != 0, 1'b0, 1'b0, 1'b1, 12'h0, 32'h0, 32'h0);
        if (kind == 0) begin
            exp_len = 1;
            return;
        end
        k = 1;
        while (qa.size() > 0) begin
            if (coll[k]) put(k, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0);
            else         put(k, 1'b1, 1'b1, 1'b0, 1'b1, qa.pop_front(), qd.pop_front(), 32'h0);
            k++;
        end
        put(k, 1'b1, 1'b0, 1'b1, 1'b1, 12'h0, 32'h0, tgt);
        k++;
        put(k, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0, 32'h0, 32'h0);
        exp_len = k + 1;
    endtask

    task automatic apply_csrs();
        bus.mstatus_i = c_ms; bus.mepc_i = c_mepc; bus.mtvec_i = c_mtvec;
        bus.mie_i = c_mie; bus.mip_i = c_mip;
    endtask

    task automatic clear_case();
        c_ecall = 0; c_ebreak = 0; c_mret = 0;
        c_pc = $urandom & ~32'h3; c_mepc = $urandom; c_mtvec = $urandom;
        c_ms = 0; c_mie = 0; c_mip = 0;
        for (int i = 0; i < 32; i++) coll[i] = 1'b0;
    endtask

    // Cycle 0 presents the request; later cycles optionally present noise that must be ignored.
    task automatic drive(input int k, input bit last, input bit noise);
        bus.ex_csr_we_i = coll[k];
        if (k == 0) begin
            bus.inst_valid_i = 1'b1; bus.inst_pc_i = c_pc;
            bus.ecall_i = c_ecall; bus.ebreak_i = c_ebreak; bus.mret_i = c_mret;
        end else if (noise && !last) begin
            bus.inst_valid_i = 1'($urandom % 2); bus.inst_pc_i = $urandom;
            bus.ecall_i = 1'($urandom % 2); bus.ebreak_i = 1'($urandom % 2); bus.mret_i = 1'($urandom % 2);
        end else begin
            bus.inst_valid_i = 1'b0; bus.inst_pc_i = 32'h0;
            bus.ecall_i = 1'b0; bus.ebreak_i = 1'b0; bus.mret_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        clear_case();
        apply_csrs();
        bus.ex_csr_we_i = 1'b0;
        bus.inst_valid_i = 1'b1; bus.inst_pc_i = 32'h40; bus.ecall_i = 1'b1;
        bus.ebreak_i = 1'b0; bus.mret_i = 1'b0;
        @(negedge clk_i); #2;
        vectors++;
        if ({bus.hold_o, bus.ctrl_we_o, bus.jump_o, bus.ctrl_waddr_o, bus.ctrl_wdata_o, bus.jump_addr_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got hold=%b we=%b jump=%b addr=%h data=%h jaddr=%h, want all 0",
                     bus.hold_o, bus.ctrl_we_o, bus.jump_o, bus.ctrl_waddr_o, bus.ctrl_wdata_o, bus.jump_addr_o);
        end
        @(negedge clk_i);
        bus.inst_valid_i = 1'b0; bus.ecall_i = 1'b0;
        rst_ni = 1'b1;
        #2;
        vectors++;
        if ({bus.hold_o, bus.ctrl_we_o, bus.jump_o, bus.ctrl_waddr_o, bus.ctrl_wdata_o} !== '0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got hold=%b we=%b jump=%b addr=%h data=%h, want all 0",
                     bus.hold_o, bus.ctrl_we_o, bus.jump_o, bus.ctrl_waddr_o, bus.ctrl_wdata_o);
        end
    endtask

    task automatic test_sequences();
        bit noise;
        for (int c = 0; c < 30; c++) begin
            clear_case();
            noise = 1'b0;
            case (c)
                0: begin c_ms = 32'h8; c_mie = 32'h80; c_mip = 32'h80; c_mtvec = 32'h50; c_pc = 32'h100; end
                1: begin c_ms = 32'h8; c_mie = 32'h80; c_mip = 32'h80; c_mtvec = 32'h51; c_pc = 32'h100; end
                2: begin c_ms = 32'h0; c_mie = 32'h80; c_mip = 32'h80; c_mtvec = 32'h50; c_pc = 32'h200;
                         c_ecall = 1; c_ebreak = 1; end
                3: begin c_ms = 32'h8; c_mie = 32'h80; c_mip = 32'h80; c_mtvec = 32'h50; c_pc = 32'h200;
                         c_ecall = 1; c_ebreak = 1; end
                4: begin c_ms = 32'h1880; c_mepc = 32'h104; c_mtvec = 32'h50; c_mret = 1; end
                5: begin c_ms = 32'h0; c_mtvec = 32'h51; c_pc = 32'h300; c_ebreak = 1; end
                default: begin
                    c_ms = $urandom; c_mie = $urandom; c_mip = $urandom;
                    c_ecall = 1'($urandom % 2); c_ebreak = 1'($urandom % 2); c_mret = 1'($urandom % 2);
                    if ($urandom % 2 == 1) c_mtvec = (c_mtvec & ~32'h3) | 32'h1;
                    noise = 1'b1;
                end
            endcase
            apply_csrs();
            model();
            for (int k = 0; k < exp_len; k++) begin
                @(negedge clk_i);
                drive(k, k == exp_len - 1, noise);
                #2;
                vectors++;
                if (bus.hold_o !== exp_hold[k] || bus.ctrl_we_o !== exp_we[k] || bus.jump_o !== exp_jump[k] ||
                    (exp_chk[k] && (bus.ctrl_waddr_o !== exp_waddr[k] || bus.ctrl_wdata_o !== exp_wdata[k])) ||
                    (exp_jump[k] && bus.jump_addr_o !== exp_jaddr[k])) begin
                    miscompares++;
                    $display("FAIL seq case %0d cyc %0d: got hold=%b we=%b %h<=%h jump=%b->%h, want hold=%b we=%b %h<=%h jump=%b->%h",
                             c, k, bus.hold_o, bus.ctrl_we_o, bus.ctrl_waddr_o, bus.ctrl_wdata_o, bus.jump_o, bus.jump_addr_o,
                             exp_hold[k], exp_we[k], exp_waddr[k], exp_wdata[k], exp_jump[k], exp_jaddr[k]);
                end
            end
        end
    endtask

    task automatic test_collision();
        for (int c = 0; c < 16; c++) begin
            clear_case();
            c_mtvec = 32'h50;
            c_ecall = 1'b1;
            if (c == 0) begin
                coll[2] = 1'b1; coll[3] = 1'b1;
            end else begin
                c_ms = $urandom; c_mie = $urandom; c_mip = $urandom; c_mtvec = $urandom;
                c_ecall = 1'($urandom % 2); c_mret = 1'b1;
                for (int i = 0; i < 10; i++) coll[i] = ($urandom % 3 == 0);
            end
            apply_csrs();
            model();
            for (int k = 0; k < exp_len; k++) begin
                @(negedge clk_i);
                drive(k, k == exp_len - 1, c != 0);
                #2;
                vectors++;
                if (bus.hold_o !== exp_hold[k] || bus.ctrl_we_o !== exp_we[k] || bus.jump_o !== exp_jump[k] ||
                    (exp_chk[k] && (bus.ctrl_waddr_o !== exp_waddr[k] || bus.ctrl_wdata_o !== exp_wdata[k])) ||
                    (exp_jump[k] && bus.jump_addr_o !== exp_jaddr[k])) begin
                    miscompares++;
                    $display("FAIL collision case %0d cyc %0d: got hold=%b we=%b %h<=%h jump=%b->%h, want hold=%b we=%b %h<=%h jump=%b->%h",
                             c, k, bus.hold_o, bus.ctrl_we_o, bus.ctrl_waddr_o, bus.ctrl_wdata_o, bus.jump_o, bus.jump_addr_o,
                             exp_hold[k], exp_we[k], exp_waddr[k], exp_wdata[k], exp_jump[k], exp_jaddr[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int stop;
        for (int pass = 0; pass < 2; pass++) begin
            clear_case();
            c_ecall = 1'b1;
            apply_csrs();
            model();
            stop = (pass == 0) ? 3 : exp_len;
            for (int k = 0; k < stop; k++) begin
                @(negedge clk_i);
                drive(k, k == exp_len - 1, 1'b0);
                #2;
                vectors++;
                if (bus.hold_o !== exp_hold[k] || bus.ctrl_we_o !== exp_we[k] || bus.jump_o !== exp_jump[k] ||
                    (exp_chk[k] && (bus.ctrl_waddr_o !== exp_waddr[k] || bus.ctrl_wdata_o !== exp_wdata[k])) ||
                    (exp_jump[k] && bus.jump_addr_o !== exp_jaddr[k])) begin
                    miscompares++;
                    $display("FAIL reset_mid pass %0d cyc %0d: got hold=%b we=%b %h<=%h jump=%b->%h, want hold=%b we=%b %h<=%h jump=%b->%h",
                             pass, k, bus.hold_o, bus.ctrl_we_o, bus.ctrl_waddr_o, bus.ctrl_wdata_o, bus.jump_o, bus.jump_addr_o,
                             exp_hold[k], exp_we[k], exp_waddr[k], exp_wdata[k], exp_jump[k], exp_jaddr[k]);
                end
            end
            if (pass == 0) begin
                #1;
                rst_ni = 1'b0;
                bus.inst_valid_i = 1'b1; bus.ecall_i = 1'b1;
                #1;
                vectors++;
                if ({bus.hold_o, bus.ctrl_we_o, bus.jump_o, bus.ctrl_waddr_o, bus.ctrl_wdata_o, bus.jump_addr_o} !== '0) begin
                    miscompares++;
                    $display("FAIL async_reset_mid: got hold=%b we=%b jump=%b addr=%h data=%h, want all 0",
                             bus.hold_o, bus.ctrl_we_o, bus.jump_o, bus.ctrl_waddr_o, bus.ctrl_wdata_o);
                end
                @(negedge clk_i);
                vectors++;
                if ({bus.hold_o, bus.ctrl_we_o, bus.jump_o, bus.ctrl_waddr_o, bus.ctrl_wdata_o} !== '0) begin
                    miscompares++;
                    $display("FAIL reset_held: got hold=%b we=%b jump=%b addr=%h data=%h, want all 0",
                             bus.hold_o, bus.ctrl_we_o, bus.jump_o, bus.ctrl_waddr_o, bus.ctrl_wdata_o);
                end
                bus.inst_valid_i = 1'b0; bus.ecall_i = 1'b0;
                rst_ni = 1'b1;
            end
        end
    endtask

    task automatic test_gating();
        clear_case();
        c_ms = 32'h8; c_mie = 32'h80; c_mip = 32'h80;
        apply_csrs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            bus.inst_valid_i = 1'b0; bus.inst_pc_i = $urandom; bus.ex_csr_we_i = 1'b0;
            #2;
            vectors++;
            if (bus.hold_o !== 1'b0 || bus.ctrl_we_o !== 1'b0 || bus.jump_o !== 1'b0) begin
                miscompares++;
                $display("FAIL gating cyc %0d: got hold=%b we=%b jump=%b, want 0 0 0",
                         i, bus.hold_o, bus.ctrl_we_o, bus.jump_o);
            end
        end
        model();
        for (int k = 0; k < exp_len; k++) begin
            @(negedge clk_i);
            drive(k, k == exp_len - 1, 1'b0);
            #2;
            vectors++;
            if (bus.hold_o !== exp_hold[k] || bus.ctrl_we_o !== exp_we[k] || bus.jump_o !== exp_jump[k] ||
                (exp_chk[k] && (bus.ctrl_waddr_o !== exp_waddr[k] || bus.ctrl_wdata_o !== exp_wdata[k])) ||
                (exp_jump[k] && bus.jump_addr_o !== exp_jaddr[k])) begin
                miscompares++;
                $display("FAIL gating_seq cyc %0d: got hold=%b we=%b %h<=%h jump=%b->%h, want hold=%b we=%b %h<=%h jump=%b->%h",
                         k, bus.hold_o, bus.ctrl_we_o, bus.ctrl_waddr_o, bus.ctrl_wdata_o, bus.jump_o, bus.jump_addr_o,
                         exp_hold[k], exp_we[k], exp_waddr[k], exp_wdata[k], exp_jump[k], exp_jaddr[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequences();
        test_collision();
        test_reset_mid();
        test_gating();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer sitting between the execute stage and the CSR register file. It samples exception and interrupt requests at instruction boundaries. It then commits mepc, mcause and mstatus through the CSR file's ctrl write port, one register per cycle, and issues a pipeline redirect to the trap vector, or back to mepc on mret. While a sequence is in progress it stalls the pipeline.

## Interface
- VECTORED_EN, default 1: honour mtvec mode 1 (vectored) for interrupts; when 0, every trap goes to the direct base.
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- inst_valid_i  in  1  a valid instruction occupies EX this cycle
- inst_pc_i  in  32  PC of that instruction
- ecall_i  in  1  EX instruction is ECALL (qualified by inst_valid_i)
- ebreak_i  in  1  EX instruction is EBREAK (qualified by inst_valid_i)
- mret_i  in  1  EX instruction is MRET (qualified by inst_valid_i)
- ex_csr_we_i  in  1  EX is writing the CSR file this cycle; the CSR file gives EX priority over ctrl
- mstatus_i, mepc_i, mtvec_i, mie_i, mip_i  in  32 each  live CSR values from the CSR file
- ctrl_waddr_o  out  12  CSR write address
- ctrl_wdata_o  out  32  CSR write data
- ctrl_we_o  out  1  CSR write strobe
- hold_o  out  1  stall IF/ID/EX and suppress EX side effects
- jump_o  out  1  one-cycle redirect strobe
- jump_addr_o  out  32  redirect target, valid only with jump_o

## Operation
- FSM states and sequences:
  - States: IDLE, WR_MEPC, WR_MCAUSE, WR_MSTATUS, MRET_WR, JUMP.
  - Trap sequence: WR_MEPC, WR_MCAUSE, WR_MSTATUS, JUMP.
  - MRET sequence: MRET_WR, JUMP.
- Interrupt pending (irq): mstatus_i[3] & mie_i[7] & mip_i[7].
- In IDLE with inst_valid_i, requests are accepted in this priority order:
  1. irq: cause 0x8000_0007.
  2. ecall_i: cause 0x0000_000B.
  3. ebreak_i: cause 0x0000_0003.
  4. mret_i.
- On acceptance:
  - The accepted instruction is not executed; hold_o covers it.
  - Register saved_pc ← inst_pc_i and saved_cause ← the cause above.
  - Next state is WR_MEPC for a trap, MRET_WR for mret.
  - Without inst_valid_i no request is accepted and an irq stays pending.
- Writes, with ctrl_we_o = 1 in the state:
  - WR_MEPC: address 0x341, data saved_pc.
  - WR_MCAUSE: address 0x342, data saved_cause.
  - WR_MSTATUS: address 0x300, data is mstatus_i with bit7 (MPIE) ← bit3, bit3 (MIE) ← 0, bits[12:11] ← 2'b11.
  - MRET_WR: address 0x300, data is mstatus_i with bit3 ← bit7, bit7 ← 1, bits[12:11] ← 2'b11.
- Port collision: in any write state with ex_csr_we_i = 1, ctrl_we_o = 0 and the state does not advance. The write is retried the next cycle.
- JUMP:
  - jump_o = 1 and ctrl_we_o = 0; next state is IDLE.
  - Trap target, base = {mtvec_i[31:2], 2'b00}: if VECTORED_EN, mtvec_i[1:0] == 1 and the cause is an interrupt, the target is base + 4·saved_cause[30:0] (timer: base + 0x1C); otherwise it is base.
  - MRET target: mepc_i.
- Outputs:
  - hold_o = (state != IDLE) | request-accepted-this-cycle.
  - ctrl_waddr_o and ctrl_wdata_o are 0 in IDLE and JUMP.
- Re-entry: when the trap's mstatus write lands, MIE = 0, so the irq cannot retrigger until mret.

## Timing
- Reset: state IDLE, saved_pc = 0, saved_cause = 0; every output is 0.
- Reset asserted mid-sequence aborts immediately to IDLE. CSR writes already issued stand; remaining writes are not issued.
- Trap, with no collisions, acceptance at cycle T:
  - T+1: mepc write.
  - T+2: mcause write.
  - T+3: mstatus write.
  - T+4: jump_o.
  - hold_o is high from T through T+4.
- MRET, acceptance at T: T+1 mstatus write, T+2 jump_o; hold_o high from T through T+2.
- Each cycle with ex_csr_we_i high during a write state adds one cycle of latency.
- CSR reads are combinational. The JUMP state reads mepc_i and mtvec_i after any preceding write has landed, so a trap handler's own mepc update is honoured.
- A request in the JUMP cycle or any non-IDLE cycle is ignored. The pipeline must re-present it after jump_o.

## Test plan
- Timer interrupt:
  - Stimulus: mstatus = 0x8, mie = 0x80, mip = 0x80, mtvec = 0x50, inst_pc = 0x100, then raise inst_valid.
  - Response: writes 0x341←0x100, 0x342←0x8000_0007, 0x300←0x1880, then jump to 0x50 at T+4.
  - The same with mtvec = 0x51 and VECTORED_EN = 1 jumps to 0x6C.
- ECALL and EBREAK:
  - Stimulus: ecall at PC 0x200, with ebreak asserted simultaneously and irq masked (mstatus = 0).
  - Response: mcause ← 0xB, jump to mtvec base.
  - With irq also pending and enabled, mcause ← 0x8000_0007.
- MRET:
  - Stimulus: mstatus = 0x1880, mepc = 0x104, mret.
  - Response: 0x300←0x1888 at T+1, jump to 0x104 at T+2.
- Port collision:
  - Stimulus: ex_csr_we_i held high for 2 cycles during WR_MCAUSE.
  - Response: ctrl_we_o stays low for 2 cycles; the mcause write follows; jump_o arrives at T+6.
- Reset during WR_MCAUSE:
  - Response: all outputs go to 0 asynchronously.
  - After release: IDLE, and a new ecall produces a full sequence.
- Gating:
  - irq pending with inst_valid_i = 0 for 3 cycles: no acceptance.
  - Acceptance occurs in the first cycle inst_valid_i = 1.
